// File: rtl/poly_alu_seq.sv
// poly_alu_seq: initiator end of the polynomial ALU enable/valid interface.
// Streams cfg_len operand sets into the ALU and writes returned results to result RAM.
module poly_alu_seq #(
  parameter int DW  = 24,
  parameter int AW  = 8,
  parameter int MW  = 10,
  parameter int LAT = 5
) (
  input  logic          poly_clk,
  input  logic          poly_rst,
  input  logic          start,
  input  logic [MW-1:0] cfg_mode,
  input  logic [AW:0]   cfg_len,
  input  logic          hold,
  output logic          busy,
  output logic          done,
  output logic          err_spurious,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data0,
  input  logic [DW-1:0] rd_data1,
  input  logic [DW-1:0] rd_data2,
  input  logic [DW-1:0] rd_data3,
  output logic          alu_enable,
  output logic [MW-1:0] alu_mode,
  output logic [DW-1:0] alu_din0,
  output logic [DW-1:0] alu_din1,
  output logic [DW-1:0] alu_din2,
  output logic [DW-1:0] alu_din3,
  input  logic          alu_valid,
  input  logic [DW-1:0] alu_dout0,
  input  logic [DW-1:0] alu_dout1,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data0,
  output logic [DW-1:0] wr_data1
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_ISSUE | reading operands and issuing them to the ALU
  // S_DRAIN | all operands issued, collecting outstanding results
  // S_DONE  | one-cycle end-of-run pulse
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int FW = $clog2(LAT + 2);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(LAT + 1);

  state_t        state_q, state_d;
  logic [AW:0]   len_q;
  logic [AW:0]   issue_cnt;
  logic [AW:0]   cap_cnt;
  logic [MW-1:0] mode_q;
  logic [FW-1:0] flush_cnt;
  logic          err_q;
  logic          alu_enable_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data0_q, wr_data1_q;

  logic accept, issue_now, flushing, in_run, expecting, capture, spurious;

  always_comb begin
    accept    = (state_q == S_IDLE) && start;
    in_run    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    issue_now = (state_q == S_ISSUE) && (issue_cnt != len_q) && !hold;
    flushing  = (flush_cnt != '0);
    expecting = in_run && (cap_cnt != len_q);
    // results still in flight from before a reset are dropped silently
    capture   = alu_valid && !flushing && expecting;
    spurious  = alu_valid && !flushing && !expecting;
  end

  always_ff @(posedge poly_clk) begin
    if (poly_rst) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (cfg_len == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (issue_cnt == len_q) state_d = S_DRAIN;
      S_DRAIN: if (cap_cnt == len_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge poly_clk) begin
    if (poly_rst) begin
      len_q        <= '0;
      mode_q       <= '0;
      issue_cnt    <= '0;
      cap_cnt      <= '0;
      flush_cnt    <= FLUSH_INIT;
      err_q        <= 1'b0;
      alu_enable_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data0_q   <= '0;
      wr_data1_q   <= '0;
    end else begin
      if (flushing) flush_cnt <= flush_cnt - 1'b1;
      alu_enable_q <= issue_now;
      wr_en_q      <= capture;
      if (accept) begin
        len_q     <= cfg_len;
        mode_q    <= cfg_mode;
        issue_cnt <= '0;
        cap_cnt   <= '0;
        err_q     <= 1'b0;
      end else begin
        if (spurious) err_q <= 1'b1;
        if (issue_now) issue_cnt <= issue_cnt + 1'b1;
        if (capture) begin
          cap_cnt    <= cap_cnt + 1'b1;
          wr_addr_q  <= cap_cnt[AW-1:0];
          wr_data0_q <= alu_dout0;
          wr_data1_q <= alu_dout1;
        end
      end
    end
  end

  assign busy         = in_run;
  assign done         = (state_q == S_DONE);
  assign err_spurious = err_q;
  assign rd_en        = issue_now;
  assign rd_addr      = issue_cnt[AW-1:0];
  assign alu_enable   = alu_enable_q;
  assign alu_mode     = mode_q;
  assign alu_din0     = rd_data0;
  assign alu_din1     = rd_data1;
  assign alu_din2     = rd_data2;
  assign alu_din3     = rd_data3;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data0     = wr_data0_q;
  assign wr_data1     = wr_data1_q;

endmodule

// File: tb/tb_poly_alu_seq.sv
// Bench for poly_alu_seq: operand RAM and fixed-latency ALU models, a result scoreboard,
// directed timing scenarios and randomized runs.
module tb_poly_alu_seq;
  localparam int DW = 24, AW = 8, MW = 10, LAT = 5, DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          poly_rst, start, hold;
  logic [MW-1:0] cfg_mode;
  logic [AW:0]   cfg_len;
  logic          busy, done, err_spurious, rd_en, alu_enable, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data0, rd_data1, rd_data2, rd_data3;
  logic [DW-1:0] alu_din0, alu_din1, alu_din2, alu_din3;
  logic [MW-1:0] alu_mode;
  logic          alu_valid;
  logic [DW-1:0] alu_dout0, alu_dout1, wr_data0, wr_data1;

  always #5 clk = ~clk;

  poly_alu_seq #(.DW(DW), .AW(AW), .MW(MW), .LAT(LAT)) dut (
    .poly_clk(clk), .poly_rst(poly_rst), .start(start), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
    .hold(hold), .busy(busy), .done(done), .err_spurious(err_spurious), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_data3(rd_data3), .alu_enable(alu_enable), .alu_mode(alu_mode), .alu_din0(alu_din0),
    .alu_din1(alu_din1), .alu_din2(alu_din2), .alu_din3(alu_din3), .alu_valid(alu_valid),
    .alu_dout0(alu_dout0), .alu_dout1(alu_dout1), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data0(wr_data0), .wr_data1(wr_data1)
  );

  logic [DW-1:0] ram0 [DEPTH];
  logic [DW-1:0] ram1 [DEPTH];
  logic [DW-1:0] ram2 [DEPTH];
  logic [DW-1:0] ram3 [DEPTH];

  int            cyc = 0;
  bit            rd_req;
  bit [AW-1:0]   rd_req_addr;
  bit            vp [LAT+1];
  bit [DW-1:0]   p0 [LAT+1];
  bit [DW-1:0]   p1 [LAT+1];
  bit            inj = 1'b0;

  // operand RAM: one-cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_req) begin
      rd_data0 <= ram0[rd_req_addr];
      rd_data1 <= ram1[rd_req_addr];
      rd_data2 <= ram2[rd_req_addr];
      rd_data3 <= ram3[rd_req_addr];
    end
  end

  // ALU: alu_valid exactly LAT cycles after alu_enable; inj forces a stray strobe
  always @(negedge clk) begin
    for (int i = LAT; i > 0; i--) begin
      vp[i] = vp[i-1];
      p0[i] = p0[i-1];
      p1[i] = p1[i-1];
    end
    vp[0] = alu_enable;
    p0[0] = alu_din0 + alu_din1 + DW'(alu_mode);
    p1[0] = alu_din2 ^ alu_din3 ^ DW'(alu_mode);
    alu_valid = vp[LAT] | inj;
    alu_dout0 = p0[LAT];
    alu_dout1 = p1[LAT];
    rd_req = rd_en;
    rd_req_addr = rd_addr;
  end

  typedef struct {
    int            addr;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
  } exp_t;

  exp_t sb[$];
  int   rd_log[$], rda_log[$], en_log[$], busy_log[$], wr_log[$], done_log[$];
  int   total = 0, bad = 0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_en) begin
        rd_log.push_back(cyc);
        rda_log.push_back(int'(rd_addr));
      end
      if (alu_enable) en_log.push_back(cyc);
      if (busy) busy_log.push_back(cyc);
      if (wr_en) begin
        wr_log.push_back(cyc);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wr_unexpected: got write addr %0d at cycle %0d, expected none", wr_addr, cyc);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data0", wr_data0, e.d0);
          chk("wr_data1", wr_data1, e.d1);
        end
      end
      if (done) begin
        done_log.push_back(cyc);
        chk("done_all_written", sb.size(), 0);
        chk("busy_at_done", busy, 0);
      end
    end
  endtask

  // hmode: 0 no hold, 1 random hold, 2 hold in T+2..T+3; restart_at issues a start while busy
  task automatic run(input int len, input int mode, input int hmode, input int restart_at,
                     output int t0);
    int d0, n, r0;
    @(posedge clk); #1;
    cfg_len  = (AW+1)'(len);
    cfg_mode = MW'(mode);
    start    = 1'b1;
    t0       = cyc;
    for (int i = 0; i < len; i++)
      sb.push_back('{addr: i, d0: DW'(ram0[i] + ram1[i] + DW'(mode)),
                     d1: ram2[i] ^ ram3[i] ^ DW'(mode)});
    d0 = done_log.size();
    r0 = rda_log.size();
    n  = 0;
    @(posedge clk); #1;
    start = 1'b0;
    while (done_log.size() == d0 && n < 3000) begin
      case (hmode)
        1:       hold = ($urandom_range(0, 3) == 0);
        2:       hold = (cyc == t0 + 2) || (cyc == t0 + 3);
        default: hold = 1'b0;
      endcase
      if (n == restart_at) begin
        start    = 1'b1;
        cfg_mode = MW'(mode ^ 'h3FF);
        cfg_len  = 9'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    hold  = 1'b0;
    start = 1'b0;
    chk("run_completes", n < 3000, 1);
    chk("rd_count", rda_log.size() - r0, len);
    for (int k = 0; k < len; k++) chk("rd_addr_seq", at(rda_log, r0 + k), k);
  endtask

  initial begin
    int t, s_rd, s_en, s_wr, s_busy, s_done, len;
    fork
      monitor();
    join_none
    for (int i = 0; i < DEPTH; i++) begin
      ram0[i] = DW'($urandom);
      ram1[i] = DW'($urandom);
      ram2[i] = DW'($urandom);
      ram3[i] = DW'($urandom);
    end
    poly_rst = 1'b1; start = 1'b0; hold = 1'b0; cfg_mode = '0; cfg_len = '0;
    rd_data0 = '0; rd_data1 = '0; rd_data2 = '0; rd_data3 = '0;
    repeat (3) @(posedge clk);
    #1 poly_rst = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_spurious, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_alu_enable", alu_enable, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_alu_mode", alu_mode, 0);

    // basic run: cycle-exact timing
    s_rd = rd_log.size(); s_en = en_log.size(); s_wr = wr_log.size(); s_busy = busy_log.size();
    run(4, 'h105, 0, -1, t);
    chk("t1_rd_first", at(rd_log, s_rd), t + 1);
    chk("t1_rd_last", at(rd_log, s_rd + 3), t + 4);
    chk("t1_en_first", at(en_log, s_en), t + 2);
    chk("t1_en_last", at(en_log, s_en + 3), t + 5);
    chk("t1_en_count", en_log.size() - s_en, 4);
    chk("t1_alu_mode", alu_mode, 'h105);
    chk("t1_wr_first", at(wr_log, s_wr), t + 8);
    chk("t1_wr_last", at(wr_log, s_wr + 3), t + 11);
    chk("t1_wr_count", wr_log.size() - s_wr, 4);
    chk("t1_done", at(done_log, done_log.size() - 1), t + 12);
    chk("t1_busy_first", at(busy_log, s_busy), t + 1);
    chk("t1_busy_count", busy_log.size() - s_busy, 11);
    chk("t1_err", err_spurious, 0);

    // zero-length run
    s_rd = rd_log.size(); s_en = en_log.size(); s_wr = wr_log.size(); s_busy = busy_log.size();
    run(0, 'h2A, 0, -1, t);
    repeat (LAT + 3) @(posedge clk);
    chk("t2_done", at(done_log, done_log.size() - 1), t + 1);
    chk("t2_no_rd", rd_log.size() - s_rd, 0);
    chk("t2_no_en", en_log.size() - s_en, 0);
    chk("t2_no_wr", wr_log.size() - s_wr, 0);
    chk("t2_no_busy", busy_log.size() - s_busy, 0);

    // hold in T+2..T+3
    s_rd = rd_log.size(); s_wr = wr_log.size();
    run(4, 'h33, 2, -1, t);
    chk("t3_rd0", at(rd_log, s_rd), t + 1);
    chk("t3_rd1", at(rd_log, s_rd + 1), t + 4);
    chk("t3_rd3", at(rd_log, s_rd + 3), t + 6);
    chk("t3_done_after_wr", at(done_log, done_log.size() - 1), at(wr_log, s_wr + 3) + 1);

    // full-depth run
    s_wr = wr_log.size(); s_done = done_log.size();
    run(DEPTH, 'h3C5, 1, -1, t);
    repeat (4) @(posedge clk);
    chk("t4_wr_count", wr_log.size() - s_wr, DEPTH);
    chk("t4_done_pulses", done_log.size() - s_done, 1);

    // start while busy is ignored; stray alu_valid in IDLE is flagged until next start
    s_wr = wr_log.size();
    run(20, 'h155, 1, 5, t);
    chk("t5_alu_mode_kept", alu_mode, 'h155);
    chk("t5_wr_count", wr_log.size() - s_wr, 20);
    repeat (LAT + 3) @(posedge clk);
    #1 inj = 1'b1;
    @(posedge clk); #1 inj = 1'b0;
    @(negedge clk);
    chk("t5_err_set", err_spurious, 1);
    repeat (5) @(negedge clk);
    chk("t5_err_sticky", err_spurious, 1);
    chk("t5_no_wr_from_stray", wr_log.size() - s_wr, 20);
    run(3, 'h7, 0, -1, t);
    chk("t5_err_cleared", err_spurious, 0);

    // reset mid-run: in-flight results are flushed silently
    @(posedge clk); #1;
    cfg_len = 9'd4; cfg_mode = 10'h099; start = 1'b1; t = cyc;
    @(posedge clk); #1 start = 1'b0;
    while (cyc < t + 6) begin
      @(posedge clk); #1;
    end
    poly_rst = 1'b1;
    @(posedge clk); #1 poly_rst = 1'b0;
    s_wr = wr_log.size();
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_rd_en", rd_en, 0);
    chk("t6_alu_enable", alu_enable, 0);
    chk("t6_wr_en", wr_en, 0);
    chk("t6_done", done, 0);
    chk("t6_alu_mode", alu_mode, 0);
    repeat (LAT + 3) @(negedge clk);
    chk("t6_no_wr", wr_log.size() - s_wr, 0);
    chk("t6_no_err", err_spurious, 0);

    // randomized runs with random hold
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 48);
      run(len, $urandom_range(0, 1023), 1, -1, t);
      chk("rand_err", err_spurious, 0);
    end
    repeat (LAT + 3) @(posedge clk);
    chk("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
